// File: rtl/mod_addsub_ctrl_if.sv
// rtl/mod_addsub_ctrl_if.sv - request and mpadder bus bundle for the modular add/sub sequencer
// master = requester plus adder side (bench), slave = sequencer.
interface mod_addsub_ctrl_if #(
   parameter int DATA_W = 1027
);
   logic              start;
   logic              subtract;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [DATA_W-1:0] in_m;
   logic [DATA_W-1:0] result;
   logic              done;
   logic              busy;
   logic              err;
   logic              add_start;
   logic              add_subtract;
   logic [DATA_W-1:0] add_in_a;
   logic [DATA_W-1:0] add_in_b;
   logic [DATA_W:0]   add_result;
   logic              add_done;

   modport master (
      output start, subtract, in_a, in_b, in_m, add_result, add_done,
      input  result, done, busy, err, add_start, add_subtract, add_in_a, add_in_b
   );

   modport slave (
      input  start, subtract, in_a, in_b, in_m, add_result, add_done,
      output result, done, busy, err, add_start, add_subtract, add_in_a, add_in_b
   );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// rtl/mod_addsub_ctrl.sv - sequences one raw add/sub plus optional +/-M correction on the shared mpadder
// All outputs are registered from the next state, so they line up with the state they belong to.
module mod_addsub_ctrl #(
   parameter int DATA_W  = 1027,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              resetn,
   mod_addsub_ctrl_if.slave  bus
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE1 = 3'd1,
      WAIT1  = 3'd2,
      ISSUE2 = 3'd3,
      WAIT2  = 3'd4,
      FIN    = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_m;
   logic              r_sub;
   logic [DATA_W-1:0] r_s;
   logic [WD_W-1:0]   r_wd;
   logic [DATA_W-1:0] r_result;
   logic              r_done;
   logic              r_busy;
   logic              r_err;
   logic              r_add_start;
   logic              r_add_sub;
   logic [DATA_W-1:0] r_add_a;
   logic [DATA_W-1:0] r_add_b;
   logic [DATA_W-1:0] w_fin_result;
   logic              w_timeout;
   logic              w_wd_expired;

   assign w_wd_expired = (r_wd == WD_W'(TIMEOUT - 1));

   always_comb begin
      w_next       = r_state;
      w_timeout    = 1'b0;
      w_fin_result = '0;
      case (r_state)
         IDLE:   if (bus.start) w_next = ISSUE1;
         ISSUE1: w_next = WAIT1;
         WAIT1: begin
            if (bus.add_done) begin
               // subtraction that did not borrow is already reduced
               if (!r_sub || bus.add_result[DATA_W]) begin
                  w_next = ISSUE2;
               end else begin
                  w_next       = FIN;
                  w_fin_result = bus.add_result[DATA_W-1:0];
               end
            end else if (w_wd_expired) begin
               w_next    = FIN;
               w_timeout = 1'b1;
            end
         end
         ISSUE2: w_next = WAIT2;
         WAIT2: begin
            if (bus.add_done) begin
               w_next = FIN;
               if (!r_sub && bus.add_result[DATA_W]) w_fin_result = r_s;
               else                                  w_fin_result = bus.add_result[DATA_W-1:0];
            end else if (w_wd_expired) begin
               w_next    = FIN;
               w_timeout = 1'b1;
            end
         end
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_m         <= '0;
         r_sub       <= 1'b0;
         r_s         <= '0;
         r_wd        <= '0;
         r_result    <= '0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_add_start <= 1'b0;
         r_add_sub   <= 1'b0;
         r_add_a     <= '0;
         r_add_b     <= '0;
      end else begin
         r_state     <= w_next;
         r_done      <= (w_next == FIN);
         r_busy      <= (w_next != IDLE);
         r_add_start <= (w_next == ISSUE1) || (w_next == ISSUE2);

         if ((r_state == WAIT1) || (r_state == WAIT2)) r_wd <= r_wd + WD_W'(1);
         else                                          r_wd <= '0;

         if ((r_state == IDLE) && bus.start) begin
            r_m     <= bus.in_m;
            r_sub   <= bus.subtract;
            r_err   <= 1'b0;
            r_add_a <= bus.in_a;
            r_add_b <= bus.in_b;
            r_add_sub <= bus.subtract;
         end

         // correction: add mode subtracts M, sub mode adds M back
         if ((r_state == WAIT1) && (w_next == ISSUE2)) begin
            r_s       <= bus.add_result[DATA_W-1:0];
            r_add_a   <= bus.add_result[DATA_W-1:0];
            r_add_b   <= r_m;
            r_add_sub <= ~r_sub;
         end

         if (w_next == FIN) r_result <= w_fin_result;
         if (w_timeout)     r_err    <= 1'b1;
      end
   end

   assign bus.result       = r_result;
   assign bus.done         = r_done;
   assign bus.busy         = r_busy;
   assign bus.err          = r_err;
   assign bus.add_start    = r_add_start;
   assign bus.add_subtract = r_add_sub;
   assign bus.add_in_a     = r_add_a;
   assign bus.add_in_b     = r_add_b;
endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// tb/tb_mod_addsub_ctrl.sv - scoreboard bench for mod_addsub_ctrl with a behavioural mpadder
// Stimulus pushes expected {result, err, latency, add_start count}; the monitor pops on done.
module tb_mod_addsub_ctrl;
   localparam int DW  = 1027;
   localparam int TO  = 15;
   localparam int LAT = 2;

   typedef struct {
      logic [DW-1:0] res;
      logic          err;
      int            lat;
      int            starts;
      int            t0;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   nstarts = 0;
   bit   no_resp = 1'b0;
   int   m_cnt = 0;
   logic [DW:0] m_res;
   exp_t q[$];

   mod_addsub_ctrl_if #(.DATA_W(DW)) bus ();

   mod_addsub_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h (low 256 bits)", tag, obs[255:0], exp[255:0]);
      end
   endtask

   // mpadder model: add_done exactly LAT cycles after the sampled add_start
   always @(negedge clk) begin
      bus.add_done = 1'b0;
      if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            bus.add_done   = 1'b1;
            bus.add_result = m_res;
         end
      end
      if (bus.add_start === 1'b1 && !no_resp) begin
         m_cnt = LAT;
         m_res = bus.add_subtract ? ({1'b0, bus.add_in_a} - {1'b0, bus.add_in_b})
                                  : ({1'b0, bus.add_in_a} + {1'b0, bus.add_in_b});
      end
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (resetn !== 1'b1) begin
         nstarts = 0;
      end else begin
         if (bus.add_start === 1'b1) nstarts++;
         if (bus.done === 1'b1) begin
            chk("done_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("result",  bus.result, e.res);
               chk("err",     bus.err, e.err);
               chk("latency", cyc - e.t0, e.lat);
               chk("add_start_count", nstarts, e.starts);
            end
            nstarts = 0;
         end
      end
   end

   task automatic issue(input logic sub, input logic [DW-1:0] a, b, m, input exp_t e);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.subtract = sub;
      bus.in_a = a; bus.in_b = b; bus.in_m = m;
      e.t0 = cyc;
      q.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.subtract = ~sub;
      bus.in_a = ~a; bus.in_b = ~b; bus.in_m = ~m;
   endtask

   task automatic req(input logic sub, input logic [DW-1:0] a, b, m);
      exp_t e;
      logic [DW:0] s;
      e.err = 1'b0;
      e.t0  = 0;
      if (!sub) begin
         s = {1'b0, a} + {1'b0, b};
         e.res    = (s >= {1'b0, m}) ? DW'(s - {1'b0, m}) : s[DW-1:0];
         e.starts = 2;
         e.lat    = 3 + 2 * LAT;
      end else if (a >= b) begin
         e.res    = a - b;
         e.starts = 1;
         e.lat    = 2 + LAT;
      end else begin
         e.res    = a + m - b;
         e.starts = 2;
         e.lat    = 3 + 2 * LAT;
      end
      issue(sub, a, b, m, e);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 80 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain", q.size(), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_result"}, bus.result, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_err"}, bus.err, 0);
      chk({tag, "_add_start"}, bus.add_start, 0);
      chk({tag, "_add_subtract"}, bus.add_subtract, 0);
      chk({tag, "_add_in_a"}, bus.add_in_a, 0);
      chk({tag, "_add_in_b"}, bus.add_in_b, 0);
   endtask

   task automatic rand_wide(output logic [DW-1:0] v);
      v = '0;
      repeat (33) v = {v[DW-33:0], 32'($urandom)};
   endtask

   initial begin
      logic [DW-1:0] ra, rb, rm;
      exp_t et;
      resetn = 1'b0;
      bus.start = 1'b0; bus.subtract = 1'b0;
      bus.in_a = '0; bus.in_b = '0; bus.in_m = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      resetn = 1'b1;

      req(1'b0, 7, 9, 13);
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      chk("result_hold", bus.result, 3);

      req(1'b0, 3, 5, 13);
      wait_drain();
      req(1'b0, 6, 7, 13);
      wait_drain();
      req(1'b1, 3, 5, 13);
      wait_drain();
      req(1'b1, 9, 4, 13);
      wait_drain();

      for (int k = 0; k < 4; k++) begin
         rand_wide(rm); rm[DW-1] = 1'b0; rm[0] = 1'b1;
         rand_wide(ra); ra = ra % rm;
         rand_wide(rb); rb = rb % rm;
         req(k[0], ra, rb, rm);
         wait_drain();
      end

      // second start while busy must be dropped
      req(1'b0, 7, 9, 13);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.subtract = 1'b0; bus.in_a = 1; bus.in_b = 1; bus.in_m = 13;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("busy_hold", bus.busy, 1);
         if (bus.done === 1'b1) break;
         @(posedge clk); #1;
      end
      wait_drain();
      repeat (6) @(posedge clk);

      // adder never answers: watchdog
      no_resp = 1'b1;
      et.res = '0; et.err = 1'b1; et.lat = 2 + TO; et.starts = 1; et.t0 = 0;
      issue(1'b0, 3, 5, 13, et);
      wait_drain();
      no_resp = 1'b0;
      chk("err_sticky", bus.err, 1);
      req(1'b0, 3, 5, 13);
      wait_drain();

      // reset during WAIT2, late add_done then arrives in IDLE
      req(1'b0, 7, 9, 13);
      repeat (4) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      chk_zero("midreset");
      q.delete();
      resetn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("late_done_ignored", bus.done, 0);
      chk("idle_after_reset", bus.busy, 0);
      req(1'b1, 9, 4, 13);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not reach its summary");
      $fatal(1);
   end
endmodule
